hazard_ctrl: RTL

- Pipeline control block that drives the stall/flush inputs of the IF/ID, ID/EX and EX/MEM pipeline registers and the PC hold.
- Consumes branch type, condition flags, halt and memory-access strobes from the EX/MEM register outputs, plus load/destination info from ID/EX and source addresses from IF/ID.
- Resolves branches in MEM and detects load-use hazards.
- Inserts wait states for a multi-cycle data memory and parks the pipeline on halt.

---
 rtl/hazard_ctrl_if.sv | 50 +++++
 rtl/hazard_ctrl.sv | 95 +++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-register status in, stall/flush/branch controls out (perf counters when HAZ_PERF_EN)
interface hazard_ctrl_if;
  logic       exmem_is_br;
  logic [2:0] exmem_brType;
  logic       exmem_zr_flag;
  logic       exmem_ov_flag;
  logic       exmem_neg_flag;
  logic       exmem_hlt;
  logic       exmem_mem_re;
  logic       exmem_mem_we;
  logic       idex_mem_re;
  logic [3:0] idex_dst_addr;
  logic [3:0] ifid_src1_addr;
  logic [3:0] ifid_src2_addr;
  logic       ifid_src1_used;
  logic       ifid_src2_used;
  logic       pc_stall;
  logic       stall_ifid;
  logic       stall_idex;
  logic       stall_exmem;
  logic       flush_ifid;
  logic       flush_idex;
  logic       flush_exmem;
  logic       br_taken;
  logic       halted;
`ifdef HAZ_PERF_EN
  logic [15:0] stall_cycles;
  logic [15:0] flush_events;
`endif
  modport master (
    output exmem_is_br, exmem_brType, exmem_zr_flag, exmem_ov_flag, exmem_neg_flag, exmem_hlt,
           exmem_mem_re, exmem_mem_we, idex_mem_re, idex_dst_addr, ifid_src1_addr, ifid_src2_addr,
           ifid_src1_used, ifid_src2_used,
    input  pc_stall, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex, flush_exmem,
           br_taken, halted
`ifdef HAZ_PERF_EN
    , input stall_cycles, flush_events
`endif
  );
  modport slave (
    input  exmem_is_br, exmem_brType, exmem_zr_flag, exmem_ov_flag, exmem_neg_flag, exmem_hlt,
           exmem_mem_re, exmem_mem_we, idex_mem_re, idex_dst_addr, ifid_src1_addr, ifid_src2_addr,
           ifid_src1_used, ifid_src2_used,
    output pc_stall, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex, flush_exmem,
           br_taken, halted
`ifdef HAZ_PERF_EN
    , output stall_cycles, flush_events
`endif
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: branch resolve, load-use, memory wait-state and halt control; HAZ_PERF_EN adds stall/flush counters
module hazard_ctrl #(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 4
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;
  localparam bit              HAS_WAIT  = MEM_LAT > 1;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(HAS_WAIT ? MEM_LAT - 2 : 0);
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [7:0]       w_cond_vec;
  logic             w_br, w_acc, w_lu, w_pc, w_bt, w_halted;
  logic [2:0]       w_st, w_fl;
  assign w_cond_vec = {1'b1, hz.exmem_ov_flag,
                       hz.exmem_zr_flag | hz.exmem_neg_flag, hz.exmem_zr_flag | ~hz.exmem_neg_flag,
                       hz.exmem_neg_flag, ~hz.exmem_zr_flag & ~hz.exmem_neg_flag,
                       hz.exmem_zr_flag, ~hz.exmem_zr_flag};
  assign w_br  = hz.exmem_is_br & w_cond_vec[hz.exmem_brType];
  assign w_acc = (hz.exmem_mem_re | hz.exmem_mem_we) & HAS_WAIT;
  assign w_lu  = hz.idex_mem_re & (|hz.idex_dst_addr) &
                 ((hz.ifid_src1_used & (hz.ifid_src1_addr == hz.idex_dst_addr)) |
                  (hz.ifid_src2_used & (hz.ifid_src2_addr == hz.idex_dst_addr)));
  // next state and control outputs; the cnt==0 wait cycle falls through to branch/load-use without retriggering
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_pc       = 1'b0;
    w_st       = 3'b000;
    w_fl       = 3'b000;
    w_bt       = 1'b0;
    w_halted   = 1'b0;
    if (r_state == HALT) begin
      w_pc     = 1'b1;
      w_st     = 3'b111;
      w_halted = 1'b1;
    end else if (r_state == MEM_WAIT && r_cnt != '0) begin
      w_pc       = 1'b1;
      w_st       = 3'b111;
      w_cnt_next = r_cnt - CNT_W'(1);
    end else if (r_state == RUN && hz.exmem_hlt) begin
      w_pc   = 1'b1;
      w_fl   = 3'b111;
      w_next = HALT;
    end else if (r_state == RUN && w_acc) begin
      w_pc       = 1'b1;
      w_st       = 3'b111;
      w_cnt_next = WAIT_INIT;
      w_next     = MEM_WAIT;
    end else begin
      w_next = RUN;
      w_fl   = w_br ? 3'b111 : (w_lu ? 3'b010 : 3'b000);
      w_bt   = w_br;
      w_pc   = ~w_br & w_lu;
      w_st   = (~w_br & w_lu) ? 3'b100 : 3'b000;
    end
  end
  // state and wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end
  assign hz.pc_stall    = ~rst & w_pc;
  assign hz.stall_ifid  = ~rst & w_st[2];
  assign hz.stall_idex  = ~rst & w_st[1];
  assign hz.stall_exmem = ~rst & w_st[0];
  assign hz.flush_ifid  = ~rst & w_fl[2];
  assign hz.flush_idex  = ~rst & w_fl[1];
  assign hz.flush_exmem = ~rst & w_fl[0];
  assign hz.br_taken    = ~rst & w_bt;
  assign hz.halted      = ~rst & w_halted;
`ifdef HAZ_PERF_EN
  logic [15:0] r_stall_cycles, r_flush_events;
  // saturating counts of stalled cycles outside halt and of taken branches
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (w_pc && r_state != HALT && r_stall_cycles != 16'hFFFF) r_stall_cycles <= r_stall_cycles + 16'd1;
      if (w_bt && r_flush_events != 16'hFFFF) r_flush_events <= r_flush_events + 16'd1;
    end
  end
  assign hz.stall_cycles = r_stall_cycles;
  assign hz.flush_events = r_flush_events;
`endif
endmodule
